// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests to
// instruction memory and queues returned words with their PC for decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);
    localparam logic [CW:0]   CREDIT   = (CW + 1)'(QDEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d;
    logic [PW-1:0] pend_wr_q, pend_wr_d;

    logic [31:0] q_data_q  [QDEPTH];
    logic [31:0] q_pc_q    [QDEPTH];
    logic [31:0] pend_pc_q [QDEPTH];

    logic credit_ok;
    logic req_fire;
    logic rsp_take;
    logic rsp_drop;
    logic rsp_push;
    logic pop;

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, and the response channel
    // has no ready (every request holds a queue slot by the credit rule).
    assign credit_ok      = ({1'b0, count_q} + {1'b0, outst_q}) < CREDIT;
    assign imem_req_valid = rst && credit_ok && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_take = imem_rsp_valid && (outst_q != '0);
    assign rsp_drop = rsp_take && (drop_q != '0);
    assign rsp_push = rsp_take && (drop_q == '0) && !redirect_valid;

    assign instr_valid = rst && (count_q != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr       = rst ? q_data_q[rd_ptr_q] : '0;
    assign instr_pc    = rst ? q_pc_q[rd_ptr_q]   : '0;

    always_comb begin
        pc_d      = pc_q;
        count_d   = count_q;
        drop_d    = drop_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        outst_d   = outst_q + CW'(req_fire) - CW'(rsp_take);
        pend_wr_d = req_fire ? ptr_inc(pend_wr_q) : pend_wr_q;
        pend_rd_d = rsp_take ? ptr_inc(pend_rd_q) : pend_rd_q;

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old
            // path, so the squash count becomes exactly the remaining
            // outstanding responses.
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            drop_d   = outst_q - CW'(rsp_take);
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (rsp_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)      rd_ptr_d = ptr_inc(rd_ptr_q);
            if (rsp_drop) drop_d = drop_q - CW'(1);
            count_d = count_q + CW'(rsp_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            pend_rd_q <= '0;
            pend_wr_q <= '0;
        end else begin
            pc_q      <= pc_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Storage is cleared on reset so the head reads zero while held in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_data_q[i]  <= '0;
                q_pc_q[i]    <= '0;
                pend_pc_q[i] <= '0;
            end
        end else begin
            if (req_fire) pend_pc_q[pend_wr_q] <= pc_q;
            if (rsp_push) begin
                q_data_q[wr_ptr_q] <= imem_rsp_data;
                q_pc_q[wr_ptr_q]   <= pend_pc_q[pend_rd_q];
            end
        end
    end

endmodule
